// File: rtl/disp_page_sequencer.sv
// disp_page_sequencer
//
// Selects one of CHANNELS {hi, lo} field pairs coming from the CPU debug taps
// and presents it as a registered display word for the seven-segment driver.
// Pages advance on a rising edge of the debounced button. In auto mode they
// also advance when a dwell timer expires. While freeze is high, the picture,
// the page and the timer all hold.
//
// Parameters
//   CHANNELS       number of display pages (2 or more)
//   FIELD_W        width of one half-field
//   TICKS_PER_PAGE auto-mode dwell per page in clk cycles (2 or more)
//   SEL_W          derived page index width (not overridable)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   ch_hi        flattened high fields, channel k at [k*FIELD_W +: FIELD_W]
//   ch_lo        flattened low fields, same layout
//   mode         0 = manual (button only), 1 = auto (timer or button)
//   next_btn     synchronised, debounced button level
//   freeze       holds disp_data, page and the dwell timer while high
//   disp_data    registered {ch_hi[page], ch_lo[page]}
//   page         current page index
//   page_strobe  one-cycle pulse in the cycle after page changes

module disp_page_sequencer #(
   parameter int CHANNELS       = 4,
   parameter int FIELD_W        = 8,
   parameter int TICKS_PER_PAGE = 50000000,
   localparam int SEL_W         = $clog2(CHANNELS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CHANNELS*FIELD_W-1:0] ch_hi,
   input  logic [CHANNELS*FIELD_W-1:0] ch_lo,
   input  logic                        mode,
   input  logic                        next_btn,
   input  logic                        freeze,
   output logic [2*FIELD_W-1:0]        disp_data,
   output logic [SEL_W-1:0]            page,
   output logic                        page_strobe
);

   localparam int CNT_W = $clog2(TICKS_PER_PAGE);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS_PER_PAGE - 1);
   localparam logic [SEL_W-1:0] PAGE_LAST = SEL_W'(CHANNELS - 1);

   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic               btn_prev;
   logic               mode_prev;
   logic               btn_edge;
   logic               tick;
   logic               adv;
   logic [SEL_W-1:0]   page_next;
   logic [FIELD_W-1:0] sel_hi;
   logic [FIELD_W-1:0] sel_lo;

   // Channel mux driven by the registered page, so a new page is visible on
   // disp_data one cycle after the page register itself changes.
   always_comb begin
      sel_hi = '0;
      sel_lo = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (page == SEL_W'(k)) begin
            sel_hi = ch_hi[k*FIELD_W +: FIELD_W];
            sel_lo = ch_lo[k*FIELD_W +: FIELD_W];
         end
      end
   end

   // Advance decision. A timer tick and a button edge in the same cycle merge
   // into one advance. Freeze masks both, so an edge seen during freeze is
   // lost rather than deferred.
   always_comb begin
      btn_edge = next_btn & ~btn_prev;
      tick     = mode & (cnt == CNT_LAST);
      adv      = ~freeze & (btn_edge | tick);
      page_next = page;
      if (adv) begin
         page_next = (page == PAGE_LAST) ? '0 : page + SEL_W'(1);
      end
   end

   // Dwell counter. A mode change always restarts the dwell, even during
   // freeze. In manual mode the counter is parked at zero so that switching
   // to auto gives a full first dwell.
   always_comb begin
      cnt_next = cnt;
      if (mode != mode_prev) begin
         cnt_next = '0;
      end else if (freeze) begin
         cnt_next = cnt;
      end else if (adv || !mode) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   // State registers. btn_prev resets high so that a button held through
   // reset is not seen as a fresh press. It tracks the button even during
   // freeze, which is what discards presses made while frozen.
   always_ff @(posedge clk) begin
      if (rst) begin
         page        <= '0;
         cnt         <= '0;
         btn_prev    <= 1'b1;
         mode_prev   <= 1'b0;
         disp_data   <= '0;
         page_strobe <= 1'b0;
      end else begin
         page        <= page_next;
         cnt         <= cnt_next;
         btn_prev    <= next_btn;
         mode_prev   <= mode;
         page_strobe <= adv;
         if (!freeze) begin
            disp_data <= {sel_hi, sel_lo};
         end
      end
   end

endmodule
